// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by an internal word FIFO.
// Optional feature macro: UART_TX_BREAK_EN (adds i_Break line-break input).

module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 607,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                        i_Clock,
   input  logic                        i_Rst,
   input  logic                        i_TX_Valid,
   input  logic [DATA_BITS-1:0]        i_TX_Data,
   output logic                        o_TX_Ready,
   input  logic [1:0]                  i_Parity_Mode,
`ifdef UART_TX_BREAK_EN
   input  logic                        i_Break,
`endif
   output logic                        o_TX_Serial,
   output logic                        o_TX_Active,
   output logic                        o_TX_Done,
   output logic [$clog2(FIFO_DEPTH):0] o_FIFO_Count
);

   localparam int AW        = $clog2(FIFO_DEPTH);
   localparam int CW        = AW + 1;
   localparam int BW        = $clog2(CLKS_PER_BIT) + 1;
   localparam int IW        = $clog2(DATA_BITS);
   localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;

   localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_CLKS - 1);
   localparam logic [BW-1:0] DONE_AT   = BW'(STOP_CLKS - 2);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
   localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

   if (CLKS_PER_BIT < 2 ||
       DATA_BITS < 5 || DATA_BITS > 9 ||
       (STOP_BITS != 1 && STOP_BITS != 2) ||
       FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
      $error("uart_tx_fifo: illegal parameter value");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BRK,
      S_BRK_REL
   } state_t;

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q;
   logic [AW-1:0]        rd_ptr_q;
   logic [CW-1:0]        count_q;
   logic [CW-1:0]        count_d;
   logic                 ready_q;
   logic                 push;
   logic                 pop;
   logic                 fifo_ne;
   logic [DATA_BITS-1:0] head_w;

   state_t               state_q;
   state_t               state_d;
   logic [BW-1:0]        baud_q;
   logic [BW-1:0]        baud_d;
   logic [IW-1:0]        idx_q;
   logic [IW-1:0]        idx_d;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] shift_d;
   logic                 par_en_q;
   logic                 par_en_d;
   logic                 par_bit_q;
   logic                 par_bit_d;
   logic                 serial_q;
   logic                 serial_d;
   logic                 active_q;
   logic                 active_d;
   logic                 done_q;
   logic                 done_d;
   logic                 load;
   logic                 bit_end;

   assign push    = i_TX_Valid && ready_q;
   assign pop     = load;
   assign fifo_ne = (count_q != '0);
   assign head_w  = mem_q[rd_ptr_q];

   // FIFO storage: written on every accepted push
   always_ff @(posedge i_Clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= i_TX_Data;
      end
   end

   // Occupancy after this edge's push and pop
   always_comb begin
      count_d = count_q + CW'(push) - CW'(pop);
   end

   // FIFO pointers, occupancy and registered ready
   always_ff @(posedge i_Clock or negedge i_Rst) begin
      if (!i_Rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
         ready_q <= (count_d != FULL);
      end
   end

   // Frame sequencer: next state, baud timing and line level
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      serial_d  = serial_q;
      active_d  = active_q;
      done_d    = 1'b0;
      load      = 1'b0;
      bit_end   = (baud_q == BIT_LAST);

      unique case (state_q)
         S_IDLE: begin
            serial_d = 1'b1;
            active_d = 1'b0;
`ifdef UART_TX_BREAK_EN
            if (i_Break) begin
               serial_d = 1'b0;
               active_d = 1'b1;
               baud_d   = '0;
               state_d  = S_BRK;
            end else if (fifo_ne) begin
               load = 1'b1;
            end
`else
            if (fifo_ne) begin
               load = 1'b1;
            end
`endif
         end

         S_START: begin
            if (bit_end) begin
               baud_d   = '0;
               idx_d    = '0;
               serial_d = shift_q[0];
               state_d  = S_DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         S_DATA: begin
            if (bit_end) begin
               baud_d = '0;
               if (idx_q == IDX_LAST) begin
                  if (par_en_q) begin
                     serial_d = par_bit_q;
                     state_d  = S_PARITY;
                  end else begin
                     serial_d = 1'b1;
                     state_d  = S_STOP;
                  end
               end else begin
                  idx_d    = idx_q + 1'b1;
                  shift_d  = shift_q >> 1;
                  serial_d = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         S_PARITY: begin
            if (bit_end) begin
               baud_d   = '0;
               serial_d = 1'b1;
               state_d  = S_STOP;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

         S_STOP: begin
            done_d = (baud_q == DONE_AT);
            if (baud_q == STOP_LAST) begin
               baud_d = '0;
`ifdef UART_TX_BREAK_EN
               if (i_Break) begin
                  serial_d = 1'b0;
                  state_d  = S_BRK;
               end else if (fifo_ne) begin
                  load = 1'b1;
               end else begin
                  active_d = 1'b0;
                  state_d  = S_IDLE;
               end
`else
               if (fifo_ne) begin
                  load = 1'b1;
               end else begin
                  active_d = 1'b0;
                  state_d  = S_IDLE;
               end
`endif
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end

`ifdef UART_TX_BREAK_EN
         S_BRK: begin
            serial_d = 1'b0;
            active_d = 1'b1;
            if (!i_Break) begin
               serial_d = 1'b1;
               baud_d   = '0;
               state_d  = S_BRK_REL;
            end
         end

         S_BRK_REL: begin
            serial_d = 1'b1;
            if (bit_end) begin
               baud_d = '0;
               if (fifo_ne) begin
                  load = 1'b1;
               end else begin
                  active_d = 1'b0;
                  state_d  = S_IDLE;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
`endif

         default: begin
            serial_d = 1'b1;
            active_d = 1'b0;
            state_d  = S_IDLE;
         end
      endcase

      if (load) begin
         shift_d   = head_w;
         par_en_d  = (i_Parity_Mode == 2'b01) ||
                     (i_Parity_Mode == 2'b10);
         par_bit_d = (^head_w) ^ (i_Parity_Mode == 2'b10);
         serial_d  = 1'b0;
         active_d  = 1'b1;
         baud_d    = '0;
         state_d   = S_START;
      end
   end

   // Sequencer state and registered line outputs
   always_ff @(posedge i_Clock or negedge i_Rst) begin
      if (!i_Rst) begin
         state_q   <= S_IDLE;
         baud_q    <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         serial_q  <= 1'b1;
         active_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         serial_q  <= serial_d;
         active_q  <= active_d;
         done_q    <= done_d;
      end
   end

   assign o_TX_Ready   = ready_q;
   assign o_TX_Serial  = serial_q;
   assign o_TX_Active  = active_q;
   assign o_TX_Done    = done_q;
   assign o_FIFO_Count = count_q;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an integrated transmit FIFO and a configurable frame format.
- Frame: 5–9 data bits, runtime-selectable parity, 1 or 2 stop bits.
- Producers push words through a valid/ready handshake. Frames are sent back-to-back with no idle gap while the FIFO holds data.
- Sits between the command/response logic and the board UART TX pin, replacing single-byte transmit paths.

Parameters:
- CLKS_PER_BIT, 607, i_Clock cycles per bit (clock freq / baud); must be ≥ 2.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- FIFO_DEPTH, 16, FIFO entries; power of two, ≥ 2.

Ports:
- i_Clock  in  1  clock
- i_Rst  in  1  asynchronous, active-low reset
- i_TX_Valid  in  1  producer has a word
- i_TX_Data  in  DATA_BITS  word to send, LSB transmitted first
- o_TX_Ready  out  1  FIFO can accept a word (not full)
- i_Parity_Mode  in  2  00 none, 01 even, 10 odd, 11 none (reserved)
- o_TX_Serial  out  1  serial line, idle high
- o_TX_Active  out  1  frame in progress
- o_TX_Done  out  1  one-cycle pulse at end of each frame
- o_FIFO_Count  out  $clog2(FIFO_DEPTH)+1  words currently queued

Behaviour:
- Reset (async assert, sync release):
  - o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_TX_Ready=1, o_FIFO_Count=0.
  - FIFO pointers cleared, state IDLE.
  - Reset mid-frame aborts the frame: line returns high immediately and queued words are discarded.
- Push:
  - Occurs at an edge where i_TX_Valid && o_TX_Ready; o_FIFO_Count increments on that edge.
  - o_TX_Ready = (count != FIFO_DEPTH), registered.
  - Valid while full is ignored (no overwrite); the producer holds data until ready.
- Pop:
  - Occurs when the FSM loads a word. Push and pop on the same edge leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- i_Parity_Mode is sampled at pop and held for the whole frame. Changing it mid-frame has no effect on the current frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: drive o_TX_Serial=1. If FIFO non-empty: pop, latch word and parity mode, o_TX_Serial<=0, o_TX_Active<=1, go to START.
  - START: hold 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: drive data[index] for CLKS_PER_BIT cycles each. After bit DATA_BITS-1, go to PARITY if parity is enabled, else STOP.
  - PARITY: drive even parity (XOR of data) or odd parity (inverted XOR) for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: drive 1 for STOP_BITS*CLKS_PER_BIT cycles. On the last cycle, pulse o_TX_Done for one cycle.
    - If the FIFO is non-empty on that cycle: pop and go straight to START (o_TX_Active stays 1, no idle bit).
    - Else: o_TX_Active<=0, go to IDLE.
- Latency: a word pushed at edge N into an empty, idle block drives the start bit from edge N+1.
- Frame length = CLKS_PER_BIT*(1+DATA_BITS+P+STOP_BITS) cycles, where P = 1 if parity is on, else 0.
- Baud counter width: $clog2(CLKS_PER_BIT)+1. The counter resets to 0 at every bit boundary.
- All outputs are registered. Illegal parameter values stop elaboration via a generate-time check.

Optional Feature:
UART_TX_BREAK_EN
- Defined: adds input i_Break (1 bit).
  - In IDLE with i_Break=1: o_TX_Serial=0, o_TX_Active=1, FIFO pops suppressed.
  - Release (i_Break=0): line returns to 1 for one full bit time (CLKS_PER_BIT cycles) before any queued frame starts. o_TX_Done does not pulse for a break.
  - i_Break asserted mid-frame takes effect only after the current frame's stop bit(s) complete.
- Undefined: port absent; behaviour exactly as above.

Test Plan:
- CLKS_PER_BIT=4, DATA_BITS=8, parity 00, push 0xA5:
  - Serial from edge N+1 is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - o_TX_Done pulses once at cycle 40 of the frame; o_TX_Active falls the next edge.
- Push 0x07 with parity 01, then 0x07 with parity 10:
  - Parity bits are 1 then 0.
  - Frames are contiguous: second start bit directly follows first stop bit, no idle cycle.
- FIFO_DEPTH=4, hold valid high with 6 words while TX is busy:
  - o_TX_Ready drops when count=4; words 5–6 are accepted only after pops.
  - All 6 words are transmitted in order.
- STOP_BITS=2, DATA_BITS=5, push 0x1F → frame length 4*(1+5+2)=32 cycles; the stop level lasts 8 cycles.
- Reset asserted mid-DATA with 3 words queued:
  - o_TX_Serial=1, o_FIFO_Count=0, o_TX_Active=0 immediately.
  - No o_TX_Done pulse afterwards.
- UART_TX_BREAK_EN: assert i_Break for 20 cycles while idle with 1 word queued:
  - Line is low for 20 cycles, then high for 4 cycles, then the frame starts.
